// File: rtl/intersection_select_pkg.sv
// intersection_select_pkg: shared field offsets and FSM states for the trilateration stage
package intersection_select_pkg;
   typedef enum logic [2:0] {IDLE, SX1, SY1, SX2, SY2, SR, CMP, DONE} state_t;
   function automatic int x_w(input int n); return 4*n+10; endfunction
   function automatic int y_w(input int n); return 3*n+7; endfunction
   function automatic int x1_lsb(input int n); return 10*n+24; endfunction
   function automatic int y1_lsb(input int n); return 7*n+17; endfunction
   function automatic int x2_lsb(input int n); return 3*n+7; endfunction
   function automatic int xa_lsb(input int n); return 2*n+1; endfunction
   function automatic int ya_lsb(input int n); return n+1; endfunction
   localparam int Y2_LSB = 0;
   localparam int RA_LSB = 0;
endpackage

// File: rtl/intersection_select_sq_unit.sv
// sq_unit: combinational signed squarer, one multiplier
module sq_unit #(parameter int W = 43) (
   input  logic signed [W-1:0]   a,
   output logic signed [2*W-1:0] p
);
   localparam int PW = 2*W;
   assign p = PW'(a) * PW'(a);
endmodule

// File: rtl/intersection_select.sv
// intersection_select: picks the candidate point closest to a third anchor circle
// using one squarer shared over five sequenced squaring steps
module intersection_select import intersection_select_pkg::*; #(parameter int N = 8) (
   input  logic                   clk,
   input  logic                   rst,
   input  logic                   in_valid,
   output logic                   in_ready,
   input  logic [14*N+33:0]       cand,
   input  logic [3*N:0]           a_init,
   output logic                   out_valid,
   input  logic                   out_ready,
   output logic signed [4*N+9:0]  x_sel,
   output logic signed [3*N+6:0]  y_sel,
   output logic                   sel,
   output logic                   tangent,
   output logic [8*N+23:0]        err
);
   localparam int XW = x_w(N);
   localparam int YW = y_w(N);
   localparam int SW = 4*N+11;
   localparam int DYW = 3*N+8;
   localparam int PW = 2*SW;
   localparam int AW = 8*N+23;
   localparam int EW = 8*N+24;
   state_t state, nxt;
   logic signed [XW-1:0] x1, x2, x1r, x2r;
   logic signed [YW-1:0] y1, y2, y1r, y2r;
   logic signed [N-1:0] xa, ya;
   logic signed [N:0] ra_in, ra;
   logic signed [SW-1:0] dx1, dx2, op;
   logic signed [DYW-1:0] dy1, dy2;
   logic [PW-1:0] prod, rsq;
   logic [AW-1:0] acc1, acc2;
   logic signed [EW-1:0] e1, e2;
   logic [EW-1:0] m1, m2;
   logic tan_r, accept, pick2;
   assign x1 = cand[x1_lsb(N) +: XW];
   assign y1 = cand[y1_lsb(N) +: YW];
   assign x2 = cand[x2_lsb(N) +: XW];
   assign y2 = cand[Y2_LSB +: YW];
   assign xa = a_init[xa_lsb(N) +: N];
   assign ya = a_init[ya_lsb(N) +: N];
   assign ra_in = a_init[RA_LSB +: N+1];
   assign in_ready = (state == IDLE) && !rst;
   assign accept = in_valid && in_ready;
   always_comb begin
      op = state == SX1 ? dx1 : state == SY1 ? SW'(dy1) : state == SX2 ? dx2 :
           state == SY2 ? SW'(dy2) : SW'(ra);
   end
   sq_unit #(.W(SW)) u_sq (.a(op), .p(prod));
   // residuals are signed even though both accumulators are non-negative
   assign e1 = EW'(acc1) - EW'(rsq);
   assign e2 = EW'(acc2) - EW'(rsq);
   assign m1 = e1[EW-1] ? -e1 : e1;
   assign m2 = e2[EW-1] ? -e2 : e2;
   assign pick2 = m2 < m1;
   always_comb begin
      nxt = state == IDLE ? (accept ? SX1 : IDLE) :
            state == DONE ? (out_ready ? IDLE : DONE) : state_t'(state + 3'd1);
   end
   always_ff @(posedge clk or posedge rst) begin
      if (rst) state <= IDLE;
      else state <= nxt;
   end
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         {x1r, y1r, x2r, y2r, ra, dx1, dx2, dy1, dy2, tan_r} <= '0;
         {acc1, acc2, rsq} <= '0;
         {out_valid, x_sel, y_sel, sel, tangent, err} <= '0;
      end else begin
         if (accept) begin
            x1r <= x1;
            y1r <= y1;
            x2r <= x2;
            y2r <= y2;
            ra <= ra_in;
            dx1 <= SW'(x1) - SW'(xa);
            dx2 <= SW'(x2) - SW'(xa);
            dy1 <= DYW'(y1) - DYW'(ya);
            dy2 <= DYW'(y2) - DYW'(ya);
            tan_r <= (x1 == x2) && (y1 == y2);
         end
         if (state == SX1) acc1 <= AW'(prod);
         if (state == SY1) acc1 <= acc1 + AW'(prod);
         if (state == SX2) acc2 <= AW'(prod);
         if (state == SY2) acc2 <= acc2 + AW'(prod);
         if (state == SR) rsq <= prod;
         if (state == CMP) begin
            out_valid <= 1'b1;
            sel <= pick2;
            x_sel <= pick2 ? x2r : x1r;
            y_sel <= pick2 ? y2r : y1r;
            err <= pick2 ? m2 : m1;
            tangent <= tan_r;
         end
         if (state == DONE && out_ready) out_valid <= 1'b0;
      end
   end
endmodule

// File: tb/tb_intersection_select.sv
// tb_intersection_select: scoreboard bench for intersection_select at N=8
module tb_intersection_select;
   localparam int N = 8;
   typedef struct {longint x; longint y; longint e; bit s; bit t;} exp_t;
   logic clk = 0, rst = 1, in_valid = 0, out_ready = 1;
   logic in_ready, out_valid, sel, tangent;
   logic [14*N+33:0] cand = '0;
   logic [3*N:0] a_init = '0;
   logic signed [4*N+9:0] x_sel;
   logic signed [3*N+6:0] y_sel;
   logic [8*N+23:0] err;
   int checks = 0, errors = 0;
   exp_t q[$];
   always #5 clk = ~clk;
   intersection_select #(.N(N)) dut (
      .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
      .cand(cand), .a_init(a_init), .out_valid(out_valid), .out_ready(out_ready),
      .x_sel(x_sel), .y_sel(y_sel), .sel(sel), .tangent(tangent), .err(err)
   );
   task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s got %0h expected %0h", tag, got, exp);
      end
   endtask
   function automatic longint absl(input longint v);
      return v < 0 ? -v : v;
   endfunction
   function automatic exp_t model(input longint x1, y1, x2, y2, xa, ya, ra);
      exp_t r;
      longint a1 = absl((x1-xa)*(x1-xa) + (y1-ya)*(y1-ya) - ra*ra);
      longint a2 = absl((x2-xa)*(x2-xa) + (y2-ya)*(y2-ya) - ra*ra);
      r.s = a2 < a1;
      r.x = r.s ? x2 : x1;
      r.y = r.s ? y2 : y1;
      r.e = r.s ? a2 : a1;
      r.t = (x1 == x2) && (y1 == y2);
      return r;
   endfunction
   task automatic drive(input longint x1, y1, x2, y2, xa, ya, ra);
      int n = 0;
      @(negedge clk);
      cand = {42'(x1), 31'(y1), 42'(x2), 31'(y2)};
      a_init = {8'(xa), 8'(ya), 9'(ra)};
      in_valid = 1;
      q.push_back(model(x1, y1, x2, y2, xa, ya, ra));
      while (!in_ready && n < 20) begin @(negedge clk); n++; end
      check("accept_timeout", 64'(n < 20), 64'd1);
      @(posedge clk); #1;
      in_valid = 0;
   endtask
   task automatic run_pair(input longint x1, y1, x2, y2, xa, ya, ra, input bit bp);
      int n = 0;
      exp_t e;
      logic [127:0] snap;
      out_ready = !bp;
      drive(x1, y1, x2, y2, xa, ya, ra);
      while (!out_valid && n < 20) begin @(posedge clk); #1; n++; end
      check("latency", 64'(n), 64'd6);
      e = q.pop_front();
      check("x_sel", x_sel, e.x);
      check("y_sel", y_sel, e.y);
      check("sel", sel, e.s);
      check("tangent", tangent, e.t);
      check("err", err, e.e);
      if (bp) begin
         snap = {x_sel, y_sel, sel, tangent, err};
         for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            in_valid = i[0];
            @(posedge clk); #1;
            check("bp_hold", {x_sel, y_sel, sel, tangent, err}, snap);
            check("bp_in_ready", in_ready, 1'b0);
            check("bp_out_valid", out_valid, 1'b1);
         end
         @(negedge clk);
         in_valid = 0;
         out_ready = 1;
      end
      @(posedge clk); #1;
      check("release_out_valid", out_valid, 1'b0);
      check("release_in_ready", in_ready, 1'b1);
   endtask
   initial begin
      #1;
      check("rst_in_ready", in_ready, 1'b0);
      check("rst_out_valid", out_valid, 1'b0);
      check("rst_outputs", {x_sel, y_sel, sel, tangent, err}, '0);
      @(negedge clk); @(negedge clk);
      rst = 0;
      #1 check("post_rst_in_ready", in_ready, 1'b1);
      run_pair(3, 4, -3, -4, 3, 0, 4, 0);
      run_pair(3, 4, -3, -4, -3, 0, 4, 0);
      run_pair(0, 5, 0, -5, 0, 0, 5, 0);
      run_pair(2, 2, 2, 2, 0, 0, 2, 0);
      for (int i = 0; i < 6; i++)
         run_pair(longint'($urandom_range(1000)) - 500, longint'($urandom_range(1000)) - 500,
                  longint'($urandom_range(1000)) - 500, longint'($urandom_range(1000)) - 500,
                  longint'($urandom_range(255)) - 128, longint'($urandom_range(255)) - 128,
                  longint'($urandom_range(200)), 0);
      run_pair(-7, 9, 11, -2, 5, -6, 13, 1);
      drive(10, 20, -10, -20, 1, 1, 3);
      void'(q.pop_front());
      repeat (3) @(posedge clk);
      #1 rst = 1;
      #1;
      check("abort_out_valid", out_valid, 1'b0);
      check("abort_in_ready", in_ready, 1'b0);
      check("abort_outputs", {x_sel, y_sel, sel, tangent, err}, '0);
      @(negedge clk);
      rst = 0;
      #1 check("abort_release_in_ready", in_ready, 1'b1);
      run_pair(3, 4, -3, -4, -3, 0, 4, 0);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
